// File: rtl/r_matrix_streamer_if.sv
// r_matrix_streamer_if: R write stream, replay handshake and status bundle
interface r_matrix_streamer_if #(
   parameter int OUT_WIDTH = 12
);
   logic                        clear;
   logic                        wr_R;
   logic signed [OUT_WIDTH-1:0] wr_R_data;
   logic [2:0]                  wr_R_row_addr;
   logic [1:0]                  wr_R_col_addr;
   logic                        qr_valid;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [OUT_WIDTH-1:0] out_data;
   logic [1:0]                  out_row;
   logic [1:0]                  out_col;
   logic                        out_last;
   logic                        done;
   logic                        resid_err;
   logic [5:0]                  wr_cnt;

   modport master (
      output clear, wr_R, wr_R_data, wr_R_row_addr, wr_R_col_addr, qr_valid, out_ready,
      input  out_valid, out_data, out_row, out_col, out_last, done, resid_err, wr_cnt
   );

   modport slave (
      input  clear, wr_R, wr_R_data, wr_R_row_addr, wr_R_col_addr, qr_valid, out_ready,
      output out_valid, out_data, out_row, out_col, out_last, done, resid_err, wr_cnt
   );
endinterface

// File: rtl/r_matrix_streamer.sv
// r_matrix_streamer: captures the 8x4 R write stream, replays the upper triangle of the 4x4 block
module r_matrix_streamer #(
   parameter int OUT_WIDTH = 12,
   parameter int TOL       = 4
) (
   input logic              clk,
   input logic              rst,
   r_matrix_streamer_if.slave bus
);
   typedef enum logic [1:0] {CAPTURE, STREAM, DONE} state_t;

   state_t                      r_state, w_state;
   logic signed [OUT_WIDTH-1:0] r_store [32];
   logic [3:0]                  r_idx, w_idx, w_nidx;
   logic [1:0]                  w_nrow, w_ncol;
   logic                        r_valid, w_valid;
   logic signed [OUT_WIDTH-1:0] r_data, w_data;
   logic [1:0]                  r_row, w_row, r_col, w_col;
   logic                        r_last, w_last;
   logic                        r_done, w_done;
   logic                        r_resid;
   logic [5:0]                  r_cnt;
   logic                        w_wr_ok, w_below, w_over, w_hit00;
   logic [OUT_WIDTH:0]          w_ext, w_mag;

   // Writes only land while capturing; clear always drops a coincident write.
   assign w_wr_ok = bus.wr_R && !bus.clear && r_state == CAPTURE;
   assign w_hit00 = w_wr_ok && bus.wr_R_row_addr == 3'd0 && bus.wr_R_col_addr == 2'd0;

   // One extra bit of magnitude so the most negative code counts as its full size.
   assign w_ext   = {bus.wr_R_data[OUT_WIDTH-1], bus.wr_R_data};
   assign w_mag   = w_ext[OUT_WIDTH] ? -w_ext : w_ext;
   assign w_below = bus.wr_R_row_addr > {1'b0, bus.wr_R_col_addr};
   assign w_over  = w_mag > (OUT_WIDTH+1)'(TOL);

   // Upper-triangle walk: beat index to (row, col) of the following beat.
   assign w_nidx = r_idx + 4'd1;
   assign w_nrow = w_nidx < 4'd4 ? 2'd0 : w_nidx < 4'd7 ? 2'd1 : w_nidx < 4'd9 ? 2'd2 : 2'd3;
   assign w_ncol = w_nidx < 4'd4 ? w_nidx[1:0] :
                   w_nidx < 4'd7 ? 2'(w_nidx - 4'd3) :
                   w_nidx < 4'd9 ? 2'(w_nidx - 4'd5) : 2'd3;

   // Next state and next registered outputs; clear overrides everything else.
   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_valid = r_valid;
      w_data  = r_data;
      w_row   = r_row;
      w_col   = r_col;
      w_last  = r_last;
      w_done  = r_done;
      if (bus.clear) begin
         w_state = CAPTURE;
         w_idx   = '0;
         w_valid = 1'b0;
         w_data  = '0;
         w_row   = '0;
         w_col   = '0;
         w_last  = 1'b0;
         w_done  = 1'b0;
      end else if (r_state == CAPTURE && bus.qr_valid) begin
         w_state = STREAM;
         w_idx   = '0;
         w_valid = 1'b1;
         w_data  = w_hit00 ? bus.wr_R_data : r_store[0];
         w_row   = '0;
         w_col   = '0;
         w_last  = 1'b0;
      end else if (r_state == STREAM && r_valid && bus.out_ready) begin
         if (r_idx == 4'd9) begin
            w_state = DONE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_done  = 1'b1;
         end else begin
            w_idx  = w_nidx;
            w_row  = w_nrow;
            w_col  = w_ncol;
            w_data = r_store[{1'b0, w_nrow, w_ncol}];
            w_last = w_nidx == 4'd9;
         end
      end
   end

   // State and beat registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= CAPTURE;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_valid <= w_valid;
         r_data  <= w_data;
         r_row   <= w_row;
         r_col   <= w_col;
         r_last  <= w_last;
         r_done  <= w_done;
      end
   end

   // Store, saturating write counter and sticky residual flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_store[i] <= '0;
         r_cnt   <= '0;
         r_resid <= 1'b0;
      end else if (bus.clear) begin
         for (int i = 0; i < 32; i++) r_store[i] <= '0;
         r_cnt   <= '0;
         r_resid <= 1'b0;
      end else if (w_wr_ok) begin
         r_store[{bus.wr_R_row_addr, bus.wr_R_col_addr}] <= bus.wr_R_data;
         r_cnt   <= r_cnt == 6'd63 ? r_cnt : r_cnt + 6'd1;
         r_resid <= r_resid | (w_below & w_over);
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.out_data  = r_data;
   assign bus.out_row   = r_row;
   assign bus.out_col   = r_col;
   assign bus.out_last  = r_last;
   assign bus.done      = r_done;
   assign bus.resid_err = r_resid;
   assign bus.wr_cnt    = r_cnt;
endmodule

// File: tb/tb_r_matrix_streamer.sv
// tb_r_matrix_streamer: randomized scenarios against a matrix-level reference model
module tb_r_matrix_streamer;
   localparam int W   = 12;
   localparam int TOL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   r_matrix_streamer_if #(.OUT_WIDTH(W)) bus();
   r_matrix_streamer #(.OUT_WIDTH(W), .TOL(TOL)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic signed [W-1:0] d;
      logic [1:0]          r;
      logic [1:0]          c;
      logic                l;
   } beat_t;

   int    vec = 0;
   int    miss = 0;
   int    m_R [8][4];
   int    m_cnt = 0;
   bit    m_resid = 1'b0;
   beat_t exp_q[$];
   beat_t got_q[$];
   int    n_bad, n_cyc;
   logic  fin_done, fin_valid;
   bit    pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   // Reference model: a plain matrix, a saturating count and a sticky flag.
   function automatic void m_zero();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) m_R[r][c] = 0;
      m_cnt   = 0;
      m_resid = 1'b0;
   endfunction

   function automatic void m_write(input int r, input int c, input int d);
      m_R[r][c] = d;
      if (m_cnt < 63) m_cnt++;
      if (r > c && (d > TOL || d < -TOL)) m_resid = 1'b1;
   endfunction

   function automatic void build_exp();
      beat_t b;
      exp_q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = r; c < 4; c++) begin
            b.d = W'(m_R[r][c]);
            b.r = 2'(r);
            b.c = 2'(c);
            b.l = (r == 3 && c == 3);
            exp_q.push_back(b);
         end
   endfunction

   task automatic idle();
      bus.clear = 1'b0;
      bus.wr_R = 1'b0;
      bus.wr_R_data = '0;
      bus.wr_R_row_addr = '0;
      bus.wr_R_col_addr = '0;
      bus.qr_valid = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic wr(input int r, input int c, input int d, input bit cap);
      bus.wr_R = 1'b1;
      bus.wr_R_row_addr = 3'(r);
      bus.wr_R_col_addr = 2'(c);
      bus.wr_R_data = W'(d);
      @(negedge clk);
      bus.wr_R = 1'b0;
      if (cap) m_write(r, c, d);
   endtask

   task automatic wr_formula();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) wr(r, c, (r <= c) ? 100*r + 10*c + 1 : 0, 1'b1);
   endtask

   task automatic rand_capture(input int n);
      int r, c, d;
      repeat (n) begin
         r = int'($urandom_range(0, 7));
         c = int'($urandom_range(0, 3));
         d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 10)) - 5;
         wr(r, c, d, 1'b1);
      end
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      m_zero();
   endtask

   task automatic start(input bit keep);
      bus.qr_valid = 1'b1;
      @(negedge clk);
      bus.qr_valid = keep;
   endtask

   // Consumer: records accepted beats, counts hold/valid-drop violations; mode 0 ready=1, 1 fixed pattern, 2 random.
   task automatic drain(input int mode, input bit noise, input int lim);
      beat_t cur, held;
      bit    stall = 1'b0;
      bit    rdy;
      int    k = 0;
      int    cyc = 0;
      got_q.delete();
      n_bad = 0;
      held = '0;
      while (k < lim && cyc < 300) begin
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
         bus.out_ready = rdy;
         if (noise) begin
            bus.wr_R = 1'($urandom_range(0, 1));
            bus.wr_R_row_addr = 3'($urandom_range(0, 7));
            bus.wr_R_col_addr = 2'($urandom_range(0, 3));
            bus.wr_R_data = W'($urandom_range(0, 4095));
            bus.qr_valid = 1'($urandom_range(0, 1));
         end
         cur = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
         if (bus.out_valid !== 1'b1 || (stall && cur !== held)) n_bad++;
         if (rdy && bus.out_valid === 1'b1) begin
            got_q.push_back(cur);
            k++;
         end
         stall = !rdy;
         held = cur;
         @(negedge clk);
         cyc++;
      end
      bus.out_ready = 1'b0;
      bus.wr_R = 1'b0;
      bus.qr_valid = 1'b0;
      n_cyc = cyc;
      fin_done = bus.done;
      fin_valid = bus.out_valid;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vec += 8;
      if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
      if (bus.out_data !== '0) begin miss++; $display("FAIL reset out_data got=%0d exp=0", bus.out_data); end
      if (bus.out_row !== 2'd0) begin miss++; $display("FAIL reset out_row got=%0d exp=0", bus.out_row); end
      if (bus.out_col !== 2'd0) begin miss++; $display("FAIL reset out_col got=%0d exp=0", bus.out_col); end
      if (bus.out_last !== 1'b0) begin miss++; $display("FAIL reset out_last got=%b exp=0", bus.out_last); end
      if (bus.done !== 1'b0) begin miss++; $display("FAIL reset done got=%b exp=0", bus.done); end
      if (bus.resid_err !== 1'b0) begin miss++; $display("FAIL reset resid_err got=%b exp=0", bus.resid_err); end
      if (bus.wr_cnt !== 6'd0) begin miss++; $display("FAIL reset wr_cnt got=%0d exp=0", bus.wr_cnt); end
      rst = 1'b0;
      @(negedge clk);
      m_zero();
   endtask

   task automatic test_full_stream();
      m_zero();
      wr_formula();
      vec += 2;
      if (bus.wr_cnt !== 6'd32) begin miss++; $display("FAIL full wr_cnt got=%0d exp=32", bus.wr_cnt); end
      if (bus.resid_err !== 1'b0) begin miss++; $display("FAIL full resid_err got=%b exp=0", bus.resid_err); end
      build_exp();
      start(1'b1);
      drain(0, 1'b1, 10);
      vec++;
      if (got_q.size() != 10) begin miss++; $display("FAIL full beats got=%0d exp=10", got_q.size()); end
      foreach (exp_q[i]) begin
         beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
         vec++;
         if (g !== exp_q[i]) begin
            miss++;
            $display("FAIL full beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
         end
      end
      vec += 5;
      if (n_bad != 0) begin miss++; $display("FAIL full hold/valid violations got=%0d exp=0", n_bad); end
      if (n_cyc != 10) begin miss++; $display("FAIL full cycles got=%0d exp=10", n_cyc); end
      if (fin_done !== 1'b1 || fin_valid !== 1'b0) begin miss++; $display("FAIL full end done=%b valid=%b exp 1/0", fin_done, fin_valid); end
      if (bus.wr_cnt !== 6'd32) begin miss++; $display("FAIL full post wr_cnt got=%0d exp=32", bus.wr_cnt); end
      if (bus.resid_err !== 1'b0) begin miss++; $display("FAIL full post resid_err got=%b exp=0", bus.resid_err); end
      bus.qr_valid = 1'b1;
      wr(6, 0, 2000, 1'b0);
      repeat (2) @(negedge clk);
      bus.qr_valid = 1'b0;
      vec += 3;
      if (bus.done !== 1'b1) begin miss++; $display("FAIL done-hold done got=%b exp=1", bus.done); end
      if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL done-hold out_valid got=%b exp=0", bus.out_valid); end
      if (bus.wr_cnt !== 6'd32 || bus.resid_err !== 1'b0) begin miss++; $display("FAIL done-hold wr_cnt=%0d resid=%b exp 32/0", bus.wr_cnt, bus.resid_err); end
   endtask

   task automatic test_backpressure();
      do_clear();
      vec += 2;
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin miss++; $display("FAIL clear done=%b valid=%b exp 0/0", bus.done, bus.out_valid); end
      if (bus.wr_cnt !== 6'd0) begin miss++; $display("FAIL clear wr_cnt got=%0d exp=0", bus.wr_cnt); end
      wr_formula();
      build_exp();
      start(1'b0);
      drain(1, 1'b0, 10);
      vec += 3;
      if (got_q.size() != 10) begin miss++; $display("FAIL bp beats got=%0d exp=10", got_q.size()); end
      if (n_bad != 0) begin miss++; $display("FAIL bp hold/valid violations got=%0d exp=0", n_bad); end
      if (fin_done !== 1'b1 || fin_valid !== 1'b0) begin miss++; $display("FAIL bp end done=%b valid=%b exp 1/0", fin_done, fin_valid); end
      foreach (exp_q[i]) begin
         beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
         vec++;
         if (g !== exp_q[i]) begin
            miss++;
            $display("FAIL bp beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
         end
      end
   endtask

   task automatic test_residual();
      do_clear();
      wr(5, 2, -5, 1'b1);
      vec++;
      if (bus.resid_err !== 1'b1) begin miss++; $display("FAIL resid (5,2)=-5 got=%b exp=1", bus.resid_err); end
      do_clear();
      wr(1, 0, 4, 1'b1);
      wr(7, 3, -4, 1'b1);
      wr(0, 3, -2048, 1'b1);
      wr(3, 3, 2047, 1'b1);
      vec++;
      if (bus.resid_err !== 1'b0) begin miss++; $display("FAIL resid at-tol/upper got=%b exp=0", bus.resid_err); end
      wr(6, 1, -2048, 1'b1);
      vec += 2;
      if (bus.resid_err !== 1'b1) begin miss++; $display("FAIL resid (6,1)=-2048 got=%b exp=1", bus.resid_err); end
      if (bus.wr_cnt !== 6'(m_cnt)) begin miss++; $display("FAIL resid wr_cnt got=%0d exp=%0d", bus.wr_cnt, m_cnt); end
      do_clear();
      wr(4, 3, 5, 1'b1);
      vec++;
      if (bus.resid_err !== 1'b1) begin miss++; $display("FAIL resid (4,3)=5 got=%b exp=1", bus.resid_err); end
   endtask

   task automatic test_collision();
      do_clear();
      wr_formula();
      bus.wr_R = 1'b1;
      bus.wr_R_row_addr = 3'd0;
      bus.wr_R_col_addr = 2'd0;
      bus.wr_R_data = W'(-777);
      bus.qr_valid = 1'b1;
      @(negedge clk);
      bus.wr_R = 1'b0;
      bus.qr_valid = 1'b0;
      m_write(0, 0, -777);
      build_exp();
      vec += 2;
      if (bus.out_valid !== 1'b1 || bus.out_data !== W'(-777)) begin miss++; $display("FAIL collide first beat valid=%b data=%0d exp 1/-777", bus.out_valid, bus.out_data); end
      if (bus.wr_cnt !== 6'd33) begin miss++; $display("FAIL collide wr_cnt got=%0d exp=33", bus.wr_cnt); end
      drain(0, 1'b0, 10);
      vec++;
      if (got_q.size() != 10 || n_bad != 0) begin miss++; $display("FAIL collide beats=%0d bad=%0d exp 10/0", got_q.size(), n_bad); end
      foreach (exp_q[i]) begin
         beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
         vec++;
         if (g !== exp_q[i]) begin
            miss++;
            $display("FAIL collide beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
         end
      end
   endtask

   task automatic test_ignored_clear();
      do_clear();
      wr_formula();
      build_exp();
      start(1'b0);
      wr(0, 1, 999, 1'b0);
      wr(5, 0, -1500, 1'b0);
      vec += 2;
      if (bus.wr_cnt !== 6'd32) begin miss++; $display("FAIL ignore wr_cnt got=%0d exp=32", bus.wr_cnt); end
      if (bus.resid_err !== 1'b0) begin miss++; $display("FAIL ignore resid_err got=%b exp=0", bus.resid_err); end
      drain(0, 1'b0, 10);
      vec++;
      if (got_q.size() != 10 || n_bad != 0) begin miss++; $display("FAIL ignore beats=%0d bad=%0d exp 10/0", got_q.size(), n_bad); end
      foreach (exp_q[i]) begin
         beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
         vec++;
         if (g !== exp_q[i]) begin
            miss++;
            $display("FAIL ignore beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
         end
      end
      bus.clear = 1'b1;
      bus.wr_R = 1'b1;
      bus.wr_R_row_addr = 3'd3;
      bus.wr_R_col_addr = 2'd3;
      bus.wr_R_data = W'(55);
      @(negedge clk);
      bus.clear = 1'b0;
      bus.wr_R = 1'b0;
      m_zero();
      vec += 2;
      if (bus.wr_cnt !== 6'd0) begin miss++; $display("FAIL clear+wr wr_cnt got=%0d exp=0", bus.wr_cnt); end
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin miss++; $display("FAIL clear+wr done=%b valid=%b exp 0/0", bus.done, bus.out_valid); end
      bus.clear = 1'b1;
      bus.qr_valid = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.qr_valid = 1'b0;
      @(negedge clk);
      vec++;
      if (bus.out_valid !== 1'b0) begin miss++; $display("FAIL clear+qr_valid out_valid got=%b exp=0", bus.out_valid); end
      build_exp();
      start(1'b0);
      drain(2, 1'b0, 10);
      vec++;
      if (got_q.size() != 10 || n_bad != 0) begin miss++; $display("FAIL empty beats=%0d bad=%0d exp 10/0", got_q.size(), n_bad); end
      foreach (exp_q[i]) begin
         beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
         vec++;
         if (g !== exp_q[i]) begin
            miss++;
            $display("FAIL empty beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
         end
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      rand_capture(30);
      build_exp();
      start(1'b0);
      drain(2, 1'b0, 5);
      foreach (got_q[i]) begin
         vec++;
         if (got_q[i] !== exp_q[i]) begin miss++; $display("FAIL arst pre beat%0d got d=%0d exp d=%0d", i, got_q[i].d, exp_q[i].d); end
      end
      #2 rst = 1'b1;
      #1;
      vec += 3;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.done !== 1'b0) begin miss++; $display("FAIL arst valid=%b last=%b done=%b exp 0/0/0", bus.out_valid, bus.out_last, bus.done); end
      if (bus.out_data !== '0 || bus.out_row !== 2'd0 || bus.out_col !== 2'd0) begin miss++; $display("FAIL arst data=%0d row=%0d col=%0d exp 0/0/0", bus.out_data, bus.out_row, bus.out_col); end
      if (bus.wr_cnt !== 6'd0 || bus.resid_err !== 1'b0) begin miss++; $display("FAIL arst wr_cnt=%0d resid=%b exp 0/0", bus.wr_cnt, bus.resid_err); end
      #1 rst = 1'b0;
      @(negedge clk);
      m_zero();
      rand_capture(25);
      build_exp();
      vec += 2;
      if (bus.wr_cnt !== 6'(m_cnt)) begin miss++; $display("FAIL arst recapture wr_cnt got=%0d exp=%0d", bus.wr_cnt, m_cnt); end
      if (bus.resid_err !== m_resid) begin miss++; $display("FAIL arst recapture resid got=%b exp=%b", bus.resid_err, m_resid); end
      start(1'b1);
      drain(2, 1'b1, 10);
      vec++;
      if (got_q.size() != 10 || n_bad != 0 || fin_done !== 1'b1) begin miss++; $display("FAIL arst restream beats=%0d bad=%0d done=%b exp 10/0/1", got_q.size(), n_bad, fin_done); end
      foreach (exp_q[i]) begin
         beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
         vec++;
         if (g !== exp_q[i]) begin
            miss++;
            $display("FAIL arst beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
         end
      end
   endtask

   task automatic test_random();
      repeat (4) begin
         do_clear();
         rand_capture(int'($urandom_range(20, 75)));
         build_exp();
         vec += 2;
         if (bus.wr_cnt !== 6'(m_cnt)) begin miss++; $display("FAIL rand wr_cnt got=%0d exp=%0d", bus.wr_cnt, m_cnt); end
         if (bus.resid_err !== m_resid) begin miss++; $display("FAIL rand resid got=%b exp=%b", bus.resid_err, m_resid); end
         start(1'($urandom_range(0, 1)));
         drain(2, 1'b1, 10);
         vec += 2;
         if (got_q.size() != 10 || n_bad != 0) begin miss++; $display("FAIL rand beats=%0d bad=%0d exp 10/0", got_q.size(), n_bad); end
         if (fin_done !== 1'b1 || fin_valid !== 1'b0 || bus.wr_cnt !== 6'(m_cnt) || bus.resid_err !== m_resid) begin
            miss++;
            $display("FAIL rand end done=%b valid=%b wr_cnt=%0d resid=%b exp 1/0/%0d/%b", fin_done, fin_valid, bus.wr_cnt, bus.resid_err, m_cnt, m_resid);
         end
         foreach (exp_q[i]) begin
            beat_t g = (i < got_q.size()) ? got_q[i] : 'x;
            vec++;
            if (g !== exp_q[i]) begin
               miss++;
               $display("FAIL rand beat%0d got d=%0d r=%0d c=%0d l=%b exp d=%0d r=%0d c=%0d l=%b", i, g.d, g.r, g.c, g.l, exp_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].l);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_backpressure();
      test_residual();
      test_collision();
      test_ignored_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/r_matrix_streamer.md
# r_matrix_streamer

Downstream consumer of `qr_cordic`. It captures the R-matrix write stream (8×4, signed 12-bit, addressed by row/col) into an internal store. Once `qr_cordic` raises `valid`, it replays the 10 upper-triangular entries of the leading 4×4 block in row-major order over a valid/ready handshake. It also flags below-diagonal residuals whose magnitude exceeds a tolerance, so later stages (back-substitution, result RAM) see a clean, ordered R.

## Interface
- `OUT_WIDTH`, 12, data width of R entries (two's complement)
- `TOL`, 4, largest allowed |value| for any entry with row > col; a larger magnitude sets `resid_err`
- `clk`  input  1  clock; all state changes on its rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `clear`  input  1  synchronous pulse: wipe the store and flags, return to CAPTURE
- `wr_R`  input  1  write strobe from `qr_cordic`
- `wr_R_data`  input  OUT_WIDTH  signed R entry
- `wr_R_row_addr`  input  3  row 0–7
- `wr_R_col_addr`  input  2  column 0–3
- `qr_valid`  input  1  `qr_cordic` `valid`; level, R complete
- `out_valid`  output  1  beat available
- `out_ready`  input  1  consumer accepts beat
- `out_data`  output  OUT_WIDTH  signed R entry
- `out_row`  output  2  row of beat (0–3)
- `out_col`  output  2  column of beat (0–3)
- `out_last`  output  1  high on the 10th beat, (3,3)
- `done`  output  1  all 10 beats accepted
- `resid_err`  output  1  sticky below-diagonal residual flag
- `wr_cnt`  output  6  number of accepted writes, saturates at 63

## Operation
- **Store:** 32 × OUT_WIDTH registers, indexed `4*row+col`. A later write to the same address overwrites the earlier one.
- **States:** CAPTURE, STREAM, DONE. Reset state is CAPTURE.
- **CAPTURE**
  - Every `wr_R` write is stored and increments `wr_cnt`.
  - Residual check on each write: if row > col and |`wr_R_data`| > `TOL`, set `resid_err`.
  - Magnitude is computed at OUT_WIDTH+1 bits, so −2048 counts as 2048.
  - Rows 4–7 are all below the diagonal and are always checked.
- **CAPTURE → STREAM:** on a rising edge that samples `qr_valid`=1.
- **STREAM**
  - Beat order by index 0–9: (0,0) (0,1) (0,2) (0,3) (1,1) (1,2) (1,3) (2,2) (2,3) (3,3).
  - The beat index advances only on `out_valid && out_ready`.
  - Writes are ignored and do not change `wr_cnt` or `resid_err`.
- **STREAM → DONE:** when beat 9 is accepted.
- **DONE**
  - `done`=1 and `out_valid`=0.
  - Writes are ignored.
  - The block stays here until `clear` or `rst`.
- **`clear`**
  - Valid in any state; zeroes the store, `wr_cnt` and `resid_err`; state becomes CAPTURE.
  - If `clear` and `wr_R` are high in the same cycle, `clear` wins and the write is dropped.
  - If `clear` and `qr_valid` are high in the same cycle, `clear` wins.
- **Outputs:** all registered.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0
  - `done`=0, `resid_err`=0, `wr_cnt`=0
  - store all 0, state CAPTURE
- **Stream start latency:** `qr_valid` sampled at edge N → `out_valid`=1 with beat 0 after edge N.
- **Write/stream collision:** a write in the same cycle that `qr_valid` is sampled is stored and counted.
  - If that write targets (0,0), `out_data` at edge N takes `wr_R_data` (bypass).
  - That write is also residual-checked.
- **Throughput:** with `out_ready` held high, one beat per cycle. 10 beats occupy edges N..N+9; `done`=1 after edge N+10.
- **Backpressure:**
  - While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
  - `out_valid` never drops without acceptance.
  - `out_valid` does not depend combinationally on `out_ready`.
- **`qr_valid` behaviour:**
  - Remaining high or toggling after the CAPTURE → STREAM transition has no effect.
  - A deassertion during STREAM does not abort the stream.
- **Mid-operation reset:** asserting `rst` in any cycle forces all reset values immediately, without waiting for a clock edge. Capture resumes on the first edge after `rst` deasserts.
- **`clear` latency:** takes effect at the edge that samples it; `out_valid`=0 after that edge.

## Test plan
- **Full capture and free-running stream:** write R row-major with R[r][c] = 100·r + 10·c + 1 for r ≤ c and 0 below the diagonal; raise `qr_valid`; hold `out_ready`=1 → 10 beats 1, 11, 21, 31, 111, 121, 131, 221, 231, 331; `out_last` only on 331; `done`=1 one cycle after the last beat; `wr_cnt`=32; `resid_err`=0.
- **Backpressure:** same data; `out_ready` pattern 1,0,0,1,0,1… → every beat delivered exactly once, in order; outputs stable while stalled.
- **Residual tolerance:** write R[5][2]=−5 → `resid_err`=1. After `clear`, write R[1][0]=4 and R[7][3]=−4 → `resid_err`=0. Write −2048 at (6,1) → `resid_err`=1.
- **Write/valid collision:** final write (0,0)=−777 in the same cycle `qr_valid` rises → first beat `out_data`=−777; `wr_cnt` includes the write.
- **Ignored writes and clear priority:**
  - During STREAM, write (0,1)=999 → stream still shows the captured value; `wr_cnt` unchanged.
  - `clear` together with `wr_R` → store empty, `wr_cnt`=0.
- **Asynchronous reset mid-stream:** pulse `rst` between edges after beat 4 → all outputs at reset values before the next edge; a new capture then runs to completion correctly.
